// File: rtl/mux_pipe_pkg.sv
// Shared limits and select helpers for the operand-select pipeline register.
package mux_pipe_pkg;

    localparam int MAX_NUM_IN = 16;

    function automatic int sel_width(input int n);
        return $clog2(n);
    endfunction

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/mux_sel.sv
// Combinational NUM_IN:1 word selector; out-of-range select yields zero.
// Latency: none (pure combinational); no flow control of its own.
module mux_sel
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        sel_word
);

    // Decode by comparison so unused select codes fall through to zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_reg.sv
// N:1 operand mux into a registered valid/ready output stage with a 1-deep skid; 1-cycle latency.
// Backpressure: in_ready = !skid_valid (registered); flush squashes both entries. MUX_PIPE_SELERR_EN adds sel_err.
module mux_pipe_reg
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_PIPE_SELERR_EN
    ,
    output logic                    sel_err
`endif
);

    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             acc;
    logic             drn;

    mux_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux_sel (
        .in_data  (in_data),
        .sel      (sel),
        .sel_word (sel_word)
    );

    assign in_ready = !skid_valid;
    assign acc      = in_valid & in_ready & !flush;
    assign drn      = out_valid & out_ready;

    // Branch order matters: a full skid must drain before any new word is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid && drn) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
        end else if (acc && (!out_valid || drn)) begin
            out_data  <= sel_word;
            out_valid <= 1'b1;
        end else if (acc && out_valid && !out_ready) begin
            skid_data  <= sel_word;
            skid_valid <= 1'b1;
        end else if (drn) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_PIPE_SELERR_EN
    logic bad_sel;
    assign bad_sel = acc && !sel_in_range(32'(sel), NUM_IN);

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (bad_sel) begin
            sel_err <= 1'b1;
        end
    end

    sel_range_chk: assert property (@(posedge clk) disable iff (!rst_n) !bad_sel);
`endif

endmodule
